// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select encodings, hazard shadow slots,
// and the decoder's NPC/WDSel encodings.
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // Per-stage tracking of an in-flight instruction's write behaviour
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             load;
    } slot_t;

    // Source operands of the instruction held in the EX slot
    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
    } src_t;

    // Decoder next-PC and write-data select encodings
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WDSEL_ALU  = 2'b00;
    localparam logic [1:0] WDSEL_MEM  = 2'b01;
    localparam logic [1:0] WDSEL_PC   = 2'b10;

    // A slot only produces a forwardable/hazardous value when it writes a non-x0 register
    function automatic logic is_producer(input slot_t s);
        return s.valid & s.regwrite & (s.rd != '0);
    endfunction

    function automatic logic src_hit(input src_t s, input slot_t p);
        return is_producer(p) &
               ((s.use_rs1 & (s.rs1 == p.rd)) | (s.use_rs2 & (s.rs2 == p.rd)));
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// EX operand forwarding select for one source register; the MEM slot beats the WB slot.
module pipe_fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic             ex_use,
    input  slot_t            mem_slot,
    input  slot_t            wb_slot,
    output fwd_sel_t         sel_c
);

    // Loads in MEM have no data yet, so only ALU results are taken from MEM
    always_comb begin
        sel_c = FWD_RF;
        if (is_producer(mem_slot) && !mem_slot.load && ex_use && (mem_slot.rd == ex_rs)) begin
            sel_c = FWD_MEM;
        end else if (is_producer(wb_slot) && (wb_slot.rd == ex_rs)) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: stalls, flushes, freezes and forwarding.
// Define HAZARD_FWD_EN to enable EX operand forwarding; otherwise every RAW dependency stalls.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_load,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        CYC_RUN,
        CYC_FREEZE,
        CYC_FLUSH,
        CYC_STALL
    } cyc_t;

    slot_t    ex_q, mem_q, wb_q;
    src_t     ex_src_q;
    slot_t    id_slot;
    src_t     id_src;
    cyc_t     cyc;
    fwd_sel_t sel_a, sel_b;
    logic     freeze;
    logic     ex_load_hit;
    logic     hazard;

    assign id_slot = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, load: id_load};
    assign id_src  = '{rs1: id_rs1, rs2: id_rs2, use_rs1: id_use_rs1, use_rs2: id_use_rs2};

    assign freeze      = mem_access & ~dmem_ready;
    assign ex_load_hit = ex_q.load & src_hit(id_src, ex_q);

`ifdef HAZARD_FWD_EN
    assign hazard = ex_load_hit;
`else
    // Without forwarding, ID must wait until producers drain past MEM (the RF is write-first)
    assign hazard = ex_load_hit | src_hit(id_src, ex_q) | src_hit(id_src, mem_q);
`endif

    // Cycle classification: freeze > redirect > hazard stall
    always_comb begin
        cyc = CYC_RUN;
        if (freeze) begin
            cyc = CYC_FREEZE;
        end else if (ex_redirect) begin
            cyc = CYC_FLUSH;
        end else if (hazard) begin
            cyc = CYC_STALL;
        end
    end

    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        ifid_clr = 1'b0;
        idex_clr = 1'b0;
        case (cyc)
            CYC_FREEZE: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            CYC_FLUSH: begin
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
            end
            CYC_STALL: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_clr = 1'b1;
            end
            default: ;
        endcase
    end

    // Shadow pipe mirrors the datapath stage registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q     <= '0;
            ex_src_q <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
        end else if (cyc != CYC_FREEZE) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (cyc == CYC_RUN) begin
                ex_q     <= id_slot;
                ex_src_q <= id_src;
            end else begin
                ex_q     <= '0;
                ex_src_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((cyc == CYC_FREEZE) || (cyc == CYC_STALL)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (cyc == CYC_FLUSH) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    pipe_fwd_sel u_fwd_a (
        .ex_rs    (ex_src_q.rs1),
        .ex_use   (ex_src_q.use_rs1),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel_c    (sel_a)
    );

    pipe_fwd_sel u_fwd_b (
        .ex_rs    (ex_src_q.rs2),
        .ex_use   (ex_src_q.use_rs2),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel_c    (sel_b)
    );

`ifdef HAZARD_FWD_EN
    assign fwd_a = sel_a;
    assign fwd_b = sel_b;
`else
    logic unused_fwd_sel;
    assign unused_fwd_sel = ^{sel_a, sel_b};
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; expectations follow HAZARD_FWD_EN when defined.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] RUN   = 7'b1111100;
    localparam logic [6:0] STALL = 7'b0011101;
    localparam logic [6:0] FLUSH = 7'b1111111;
    localparam logic [6:0] FRZ   = 7'b0000000;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
        logic [31:0] fc;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } exp_item_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_regwrite, id_load;
    logic        ex_redirect, mem_access, dmem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    exp_item_t sb[$];
    int        n_tests = 0;
    int        n_fail  = 0;

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_load     (id_load),
        .ex_redirect (ex_redirect),
        .mem_access  (mem_access),
        .dmem_ready  (dmem_ready),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_clr    (ifid_clr),
        .idex_clr    (idex_clr),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t o(input logic [6:0] ctl, input int fa, input int fb,
                               input int sc, input int fc);
        obs_t r;
        r.ctl = ctl;
        r.fa  = 2'(fa);
        r.fb  = 2'(fb);
        r.sc  = 32'(sc);
        r.fc  = 32'(fc);
        return r;
    endfunction

    task automatic id_set(input int rd, input int rw, input int ld,
                          input int rs1, input int u1, input int rs2, input int u2);
        id_rd       = 5'(rd);
        id_regwrite = 1'(rw);
        id_load     = 1'(ld);
        id_rs1      = 5'(rs1);
        id_use_rs1  = 1'(u1);
        id_rs2      = 5'(rs2);
        id_use_rs2  = 1'(u2);
    endtask

    task automatic nop();
        id_set(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ctl_set(input int redir, input int macc, input int rdy);
        ex_redirect = 1'(redir);
        mem_access  = 1'(macc);
        dmem_ready  = 1'(rdy);
    endtask

    task automatic chk(input string nm, input obs_t e);
        exp_item_t it;
        it.name = nm;
        it.exp  = e;
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rstn = 1'b0;
        nop();
        ctl_set(0, 0, 1);
        step();
        chk("reset", o(RUN, 0, 0, 0, 0));
        step();
        rstn = 1'b1;
    endtask

    // Monitor: every negedge with a pending expectation compares the live outputs
    exp_item_t m_it;
    obs_t      m_act;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_it  = sb.pop_front();
            m_act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr,
                     fwd_a, fwd_b, stall_cnt, flush_cnt};
            n_tests++;
            if (m_act !== m_it.exp) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b fwd=%b/%b stall=%0d flush=%0d, want ctl=%b fwd=%b/%b stall=%0d flush=%0d",
                         m_it.name, m_act.ctl, m_act.fa, m_act.fb, m_act.sc, m_act.fc,
                         m_it.exp.ctl, m_it.exp.fa, m_it.exp.fb, m_it.exp.sc, m_it.exp.fc);
            end
        end
    end

    initial begin
        int fs;
        rstn = 1'b0;
        nop();
        ctl_set(0, 0, 1);

        // lw x5,0(x1) ; add x6,x5,x2
        rst_pulse();
        id_set(5, 1, 1, 1, 1, 0, 0);  chk("s1_lw", o(RUN, 0, 0, 0, 0));  step();
        id_set(6, 1, 0, 5, 1, 2, 1);  chk("s1_stall", o(STALL, 0, 0, 0, 0));  step();
`ifdef HAZARD_FWD_EN
        chk("s1_resume", o(RUN, 0, 0, 1, 0));  step();
        nop();  chk("s1_fwd_wb", o(RUN, 2, 0, 1, 0));  step();
        chk("s1_cnt", o(RUN, 0, 0, 1, 0));  step();
`else
        chk("s1_stall2", o(STALL, 0, 0, 1, 0));  step();
        chk("s1_resume", o(RUN, 0, 0, 2, 0));  step();
        nop();  chk("s1_cnt", o(RUN, 0, 0, 2, 0));  step();
`endif

        // addi x3,x0,7 ; sub x4,x3,x3
        rst_pulse();
        id_set(3, 1, 0, 0, 1, 0, 0);  chk("s2_addi", o(RUN, 0, 0, 0, 0));  step();
        id_set(4, 1, 0, 3, 1, 3, 1);
`ifdef HAZARD_FWD_EN
        chk("s2_nostall", o(RUN, 0, 0, 0, 0));  step();
        nop();  chk("s2_fwd_mem", o(RUN, 1, 1, 0, 0));  step();
        chk("s2_cnt", o(RUN, 0, 0, 0, 0));  step();
`else
        chk("s2_stall1", o(STALL, 0, 0, 0, 0));  step();
        chk("s2_stall2", o(STALL, 0, 0, 1, 0));  step();
        chk("s2_resume", o(RUN, 0, 0, 2, 0));  step();
        nop();  chk("s2_cnt", o(RUN, 0, 0, 2, 0));  step();
`endif

        // addi x7 ; addi x7 ; or x9,x7,x0
        rst_pulse();
        id_set(7, 1, 0, 0, 1, 0, 0);  chk("s3_addi_a", o(RUN, 0, 0, 0, 0));  step();
        id_set(7, 1, 0, 0, 1, 0, 0);  chk("s3_addi_b", o(RUN, 0, 0, 0, 0));  step();
        id_set(9, 1, 0, 7, 1, 0, 1);
`ifdef HAZARD_FWD_EN
        chk("s3_or_id", o(RUN, 0, 0, 0, 0));  step();
        nop();  chk("s3_mem_over_wb", o(RUN, 1, 0, 0, 0));  step();
`else
        chk("s3_stall1", o(STALL, 0, 0, 0, 0));  step();
        chk("s3_stall2", o(STALL, 0, 0, 1, 0));  step();
        chk("s3_resume", o(RUN, 0, 0, 2, 0));  step();
        nop();  chk("s3_cnt", o(RUN, 0, 0, 2, 0));  step();
`endif

        // addi x0,x0,1 ; add x8,x0,x0
        rst_pulse();
        id_set(0, 1, 0, 0, 1, 0, 0);  chk("s4_addi_x0", o(RUN, 0, 0, 0, 0));  step();
        id_set(8, 1, 0, 0, 1, 0, 1);  chk("s4_no_stall", o(RUN, 0, 0, 0, 0));  step();
        nop();  chk("s4_x0_fwd", o(RUN, 0, 0, 0, 0));  step();

        // Redirect coinciding with load-use
        rst_pulse();
        id_set(5, 1, 1, 1, 1, 0, 0);  chk("s5_lw", o(RUN, 0, 0, 0, 0));  step();
        id_set(6, 1, 0, 5, 1, 2, 1);  ctl_set(1, 0, 1);
        chk("s5_redirect", o(FLUSH, 0, 0, 0, 0));  step();
        nop();  ctl_set(0, 0, 1);  chk("s5_after", o(RUN, 0, 0, 0, 1));  step();

        // Freeze coinciding with load-use: freeze counted, stall follows
        rst_pulse();
        id_set(5, 1, 1, 1, 1, 0, 0);  chk("s7_lw", o(RUN, 0, 0, 0, 0));  step();
        id_set(6, 1, 0, 5, 1, 2, 1);  ctl_set(0, 1, 0);
        chk("s7_frz_lu", o(FRZ, 0, 0, 0, 0));  step();
        ctl_set(0, 0, 1);  chk("s7_lu_after", o(STALL, 0, 0, 1, 0));  step();

        // Freeze for three cycles, then reset while still frozen
        rst_pulse();
        id_set(3, 1, 0, 0, 1, 0, 0);  chk("s6_addi", o(RUN, 0, 0, 0, 0));  step();
`ifdef HAZARD_FWD_EN
        fs = 1;
        id_set(4, 1, 0, 3, 1, 3, 1);
`else
        fs = 0;
        nop();
`endif
        chk("s6_pre", o(RUN, 0, 0, 0, 0));  step();
        nop();  ctl_set(0, 1, 0);
        chk("s6_frz1", o(FRZ, fs, fs, 0, 0));  step();
        chk("s6_frz2", o(FRZ, fs, fs, 1, 0));  step();
        chk("s6_frz3", o(FRZ, fs, fs, 2, 0));  step();
        chk("s6_frz_cnt", o(FRZ, fs, fs, 3, 0));
        @(negedge clk);
        #1;
        rstn = 1'b0;
        chk("s6_rst_mid", o(FRZ, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        rstn = 1'b1;
        ctl_set(0, 0, 1);
        step();
        chk("s6_post", o(RUN, 0, 0, 0, 0));  step();

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined RV32I core (IF, ID, EX, MEM, WB). It tracks a shadow copy of the destination, register-write and load flags for every in-flight instruction. From these it drives the stage-register enables and clears: load-use stall, control-transfer flush, and data-memory wait freeze. It also produces the EX-stage operand forwarding selects and keeps two performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2.
- id_rd  in  5  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes a register (decoder RegWrite).
- id_load  in  1  ID instruction is a load (WDSel == 2'b01).
- ex_redirect  in  1  taken branch, jal or jalr resolved in EX this cycle.
- mem_access  in  1  instruction in MEM is a load or store.
- dmem_ready  in  1  data memory completes this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register write enables.
- ifid_clr, idex_clr  out  1 each  synchronous bubble insertion into IF/ID and ID/EX.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 MEM ALU result, 10 WB write data.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- Shadow pipe has three slots: EX, MEM and WB. Each slot holds {valid, rd, regwrite, load}. The EX slot additionally holds {rs1, rs2, use_rs1, use_rs2}.
- A slot is a "producer" only when valid & regwrite & rd != 0.
- Freeze = mem_access & ~dmem_ready. Effects:
  - All enables are 0 and both clears are 0.
  - The shadow pipe holds.
  - The datapath holds EX, so ex_redirect stays stable.
- Redirect (when not frozen) has priority over load-use:
  - pc_en = 1, ifid_en = 1, ifid_clr = 1, idex_clr = 1.
  - The EX slot is loaded invalid.
- Load-use (when not frozen and no redirect): the EX slot is a load producer and its rd equals a used ID source.
  - pc_en = 0, ifid_en = 0, idex_clr = 1.
  - The EX slot becomes a bubble.
  - MEM and WB slots advance normally.
- Normal cycle: all enables 1, clears 0. Shadow advances EX←ID, MEM←EX, WB←MEM.
- Forwarding (fwd_a shown; fwd_b is identical on rs2):
  - 01 if the MEM slot is a non-load producer with rd == EX rs1 and use_rs1.
  - Otherwise 10 if the WB slot is a producer with rd == EX rs1.
  - Otherwise 00.
  - MEM has priority over WB. x0 is never forwarded.
- The register file is write-first, so an ID read of a WB destination needs no action.
- stall_cnt increments on every cycle with load-use or freeze active. flush_cnt increments on every redirect cycle. Both wrap modulo 2^CNT_W.

## Timing
- All outputs except the counters are combinational from the shadow state plus the current inputs, with zero-cycle latency.
- Shadow state and counters update on the rising edge.
- Reset (asynchronous, mid-operation allowed): all slots invalid and counters 0. The resulting outputs are:
  - enables = 1, clears = 0, fwd = 00, unless freeze inputs are active.
- A load-use stall lasts exactly 1 cycle. The load then sits in MEM, which is not forwardable, and reaches WB the next cycle, where the select is 10.
- Redirect coinciding with load-use: redirect wins, the stall is suppressed and stall_cnt does not count.
- Freeze coinciding with redirect or load-use: freeze wins. The other event is re-evaluated when the freeze ends, and only freeze is counted.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described.
- HAZARD_FWD_EN undefined:
  - fwd_a = fwd_b = 00 permanently.
  - Any used ID source matching a producer in the EX or MEM slot stalls, exactly like load-use.
  - The stall repeats each cycle until no match remains.

## Structure
- Shared package pipe_pkg holds:
  - the fwd_sel_t encodings FWD_RF/FWD_MEM/FWD_WB;
  - the shadow slot struct;
  - the NPC/WDSel constants already used by the decoder.
- Sub-module pipe_fwd_sel: one instance per EX operand, computing the 2-bit select from EX rs, use flag and the MEM/WB slots.

## Test plan
- Back-to-back dependency: `lw x5,0(x1)` then `add x6,x5,x2`.
  - Expect one cycle of pc_en = 0, ifid_en = 0, idex_clr = 1, then fwd_a = 10 in the add's EX cycle.
  - stall_cnt = 1.
- Back-to-back ALU dependency: `addi x3,x0,7` then `sub x4,x3,x3`.
  - Expect fwd_a = fwd_b = 01 and no stall.
  - With HAZARD_FWD_EN undefined, expect 2 stall cycles instead.
- Double write, then use: `addi x7`, `addi x7`, then `or` using x7.
  - Expect fwd_a = 01, because the MEM slot beats the WB slot.
- Writes to x0: `addi x0,x0,1` followed by `add x8,x0,x0`.
  - Expect fwd = 00 and no stall.
- Redirect during load-use: ex_redirect = 1 in the same cycle as a load-use match.
  - Expect ifid_clr = idex_clr = 1, pc_en = 1, flush_cnt += 1, stall_cnt unchanged.
- Freeze then reset: dmem_ready = 0 for 3 cycles with mem_access = 1.
  - Expect all enables = 0 for 3 cycles and stall_cnt += 3.
  - Assert rstn = 0 mid-freeze: counters read 0 and fwd = 00 immediately.
